bit_aligner_gen2: RTL

Parametrised word/bit aligner for a serial transceiver RX path. It sits between the transceiver RX parallel output and the deframer. It searches for a configurable alignment word by issuing RXSLIDE pulses, tracks the current slip position, and detects and corrects inverted lane polarity. It reports a failed full sweep, and it drops lock and re-searches when headers stop arriving.

---
 rtl/bit_aligner_gen2_pkg.sv | 17 +
 rtl/bit_aligner_gen2_cmp.sv | 33 +++
 rtl/bit_aligner_gen2.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_aligner_gen2_pkg.sv
// bit_align_pkg: shared types and defaults for the bit_aligner_gen2 RX aligner.
//   align_state_t  : aligner FSM states
//   DEF_ALIGN_WORD : default alignment header
//   DEF_IDLE_WORD  : default idle word (keeps lock alive)
//   DEF_ERR_W      : width of a Hamming-distance value for the default W
package bit_align_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED} align_state_t;

  localparam logic [31:0] DEF_ALIGN_WORD = 32'hEB94_BDA3;
  localparam logic [31:0] DEF_IDLE_WORD  = 32'h0707_0707;
  localparam int          DEF_W          = 32;
  localparam int          DEF_ERR_W      = $clog2(DEF_W + 1);

  function automatic int err_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bit_aligner_gen2_cmp.sv
// align_word_cmp: combinational header matcher.
//   i_valid/i_data : RX word and qualifier
//   i_err_th       : max Hamming distance still counted as a hit
//   o_hit_n        : word matches ALIGN_WORD
//   o_hit_i        : word matches ~ALIGN_WORD (suppressed when o_hit_n is set)
module align_word_cmp import bit_align_pkg::*; #(
  parameter int           W          = 32,
  parameter logic [W-1:0] ALIGN_WORD = W'(DEF_ALIGN_WORD)
) (
  input  logic                   i_valid,
  input  logic [W-1:0]           i_data,
  input  logic [$clog2(W+1)-1:0] i_err_th,
  output logic                   o_hit_n,
  output logic                   o_hit_i
);
  localparam int CW = err_w(W);

  logic [W-1:0]  w_diff;
  logic [CW-1:0] w_dist_n;
  logic [CW-1:0] w_dist_i;

  assign w_diff = i_data ^ ALIGN_WORD;

  always_comb begin
    w_dist_n = '0;
    for (int b = 0; b < W; b++) w_dist_n = w_dist_n + CW'(w_diff[b]);
  end

  // Distance to the inverted header is the complement count.
  assign w_dist_i = CW'(W) - w_dist_n;
  assign o_hit_n  = i_valid && (w_dist_n <= i_err_th);
  assign o_hit_i  = i_valid && (w_dist_i <= i_err_th) && !o_hit_n;
endmodule

// File: rtl/bit_aligner_gen2.sv
// bit_aligner_gen2: RX word/bit aligner with RXSLIDE search and polarity detect.
//   clk, rst (sync, active-high), rx_reset_done, rx_cdr_stable : control
//   i_rx_data/i_rx_valid : raw RX words;  i_realign_req : force re-search
//   cfg_err_th / cfg_verify_cnt / cfg_lock_loss_to : live configuration
//   o_rxslide, o_slip_pos : slide pulse and current slip offset
//   o_polarity_inv, o_bit_locked, o_align_fail : status
//   o_data_aligned/o_aligned_valid : polarity-corrected data, valid only while locked
//   o_slip_total/o_unlock_cnt : saturating stats, live only with BIT_ALIGNER_STATS_EN
module bit_aligner_gen2 import bit_align_pkg::*; #(
  parameter int           W              = 32,
  parameter logic [W-1:0] ALIGN_WORD     = W'(DEF_ALIGN_WORD),
  parameter logic [W-1:0] IDLE_WORD      = W'(DEF_IDLE_WORD),
  parameter int           SLIDE_COOLDOWN = 5,
  parameter int           CHECK_TIMEOUT  = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_reset_done,
  input  logic                   rx_cdr_stable,
  input  logic [W-1:0]           i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_realign_req,
  input  logic [$clog2(W+1)-1:0] cfg_err_th,
  input  logic [7:0]             cfg_verify_cnt,
  input  logic [15:0]            cfg_lock_loss_to,
  output logic                   o_rxslide,
  output logic [$clog2(W)-1:0]   o_slip_pos,
  output logic                   o_polarity_inv,
  output logic                   o_align_fail,
  output logic                   o_bit_locked,
  output logic [W-1:0]           o_data_aligned,
  output logic                   o_aligned_valid,
  output logic [15:0]            o_slip_total,
  output logic [7:0]             o_unlock_cnt
);
  localparam int POS_W = $clog2(W);
  localparam int CW    = err_w(W);
  localparam int TO_W  = (CHECK_TIMEOUT  > 0) ? $clog2(CHECK_TIMEOUT + 1)  : 1;
  localparam int CD_W  = (SLIDE_COOLDOWN > 0) ? $clog2(SLIDE_COOLDOWN + 1) : 1;

  align_state_t r_state, w_state_nx;
  logic [7:0]       r_verify, w_verify_nx;
  logic [TO_W-1:0]  r_to, w_to_nx;
  logic [15:0]      r_loss, w_loss_nx;
  logic [CD_W-1:0]  r_cool, w_cool_nx;
  logic [CW-1:0]    r_sweep, w_sweep_nx;
  logic [POS_W-1:0] r_slip_pos, w_pos_nx;
  logic             r_cand_pol, w_cand_nx;
  logic             r_pol_inv, w_pol_nx;
  logic             r_rxslide, w_slide_nx;
  logic             r_fail, w_fail_nx;
  logic [W-1:0]     r_data;
  logic             r_avalid;

  logic       w_hit_n, w_hit_i, w_hit, w_keep, w_abort, w_unlock, w_dp_pol;
  logic [7:0] w_vth;

  align_word_cmp #(.W(W), .ALIGN_WORD(ALIGN_WORD)) u_cmp (
    .i_valid (i_rx_valid),
    .i_data  (i_rx_data),
    .i_err_th(cfg_err_th),
    .o_hit_n (w_hit_n),
    .o_hit_i (w_hit_i)
  );

  assign w_hit   = w_hit_n | w_hit_i;
  assign w_vth   = (cfg_verify_cnt == 8'd0) ? 8'd1 : cfg_verify_cnt;
  assign w_abort = !rx_cdr_stable || !rx_reset_done || i_realign_req;
  // While locked, a header of the locked polarity or a corrected idle keeps lock alive.
  assign w_keep  = (r_pol_inv ? w_hit_i : w_hit_n) ||
                   ((i_rx_data ^ {W{r_pol_inv}}) == IDLE_WORD);
  assign w_dp_pol = (r_state == ST_LOCKED) ? r_pol_inv : r_cand_pol;

  always_comb begin
    w_state_nx  = r_state;
    w_verify_nx = r_verify;
    w_to_nx     = r_to;
    w_loss_nx   = r_loss;
    w_cool_nx   = r_cool;
    w_sweep_nx  = r_sweep;
    w_pos_nx    = r_slip_pos;
    w_cand_nx   = r_cand_pol;
    w_pol_nx    = r_pol_inv;
    w_slide_nx  = 1'b0;
    w_fail_nx   = 1'b0;
    w_unlock    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nx = ST_SEARCH;
      ST_SEARCH: begin
        if (w_hit) begin
          w_to_nx = '0;
          // First hit or polarity flip restarts verification on the new polarity.
          if (r_verify == 8'd0 || w_hit_i != r_cand_pol) begin
            w_cand_nx   = w_hit_i;
            w_verify_nx = 8'd1;
          end else if (r_verify != 8'hFF) begin
            w_verify_nx = r_verify + 8'd1;
          end
          if (w_verify_nx >= w_vth) begin
            w_state_nx = ST_LOCKED;
            w_pol_nx   = w_cand_nx;
            w_loss_nx  = '0;
          end
        end else if (i_rx_valid) begin
          if (r_to == TO_W'(CHECK_TIMEOUT)) begin
            w_state_nx  = ST_SLIP;
            w_verify_nx = '0;
            w_to_nx     = '0;
          end else begin
            w_to_nx = r_to + 1'b1;
          end
        end
      end
      ST_SLIP: begin
        w_slide_nx = 1'b1;
        w_pos_nx   = (r_slip_pos == POS_W'(W - 1)) ? '0 : r_slip_pos + 1'b1;
        if (r_sweep == CW'(W - 1)) begin
          w_fail_nx  = 1'b1;
          w_sweep_nx = '0;
        end else begin
          w_sweep_nx = r_sweep + 1'b1;
        end
        if (SLIDE_COOLDOWN == 0) begin
          w_state_nx = ST_SEARCH;
        end else begin
          w_cool_nx  = CD_W'(SLIDE_COOLDOWN);
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cool <= CD_W'(1)) begin
          w_cool_nx  = '0;
          w_state_nx = ST_SEARCH;
        end else begin
          w_cool_nx = r_cool - 1'b1;
        end
      end
      ST_LOCKED: begin
        if (i_rx_valid) begin
          if (w_keep) begin
            w_loss_nx = '0;
          end else if (cfg_lock_loss_to != 16'd0 &&
                       ({1'b0, r_loss} + 17'd1) >= {1'b0, cfg_lock_loss_to}) begin
            // >= so that lowering the timeout while locked acts at once.
            w_unlock    = 1'b1;
            w_state_nx  = ST_SEARCH;
            w_verify_nx = '0;
            w_to_nx     = '0;
            w_sweep_nx  = '0;
            w_loss_nx   = '0;
          end else if (r_loss != 16'hFFFF) begin
            w_loss_nx = r_loss + 16'd1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // Abort overrides everything, including a slide about to be issued.
    if (w_abort) begin
      w_state_nx  = ST_IDLE;
      w_verify_nx = '0;
      w_to_nx     = '0;
      w_loss_nx   = '0;
      w_cool_nx   = '0;
      w_sweep_nx  = '0;
      w_slide_nx  = 1'b0;
      w_fail_nx   = 1'b0;
      w_unlock    = 1'b0;
      w_pos_nx    = rx_reset_done ? r_slip_pos : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_verify   <= '0;
      r_to       <= '0;
      r_loss     <= '0;
      r_cool     <= '0;
      r_sweep    <= '0;
      r_slip_pos <= '0;
      r_cand_pol <= 1'b0;
      r_pol_inv  <= 1'b0;
      r_rxslide  <= 1'b0;
      r_fail     <= 1'b0;
      r_data     <= '0;
      r_avalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_verify   <= w_verify_nx;
      r_to       <= w_to_nx;
      r_loss     <= w_loss_nx;
      r_cool     <= w_cool_nx;
      r_sweep    <= w_sweep_nx;
      r_slip_pos <= w_pos_nx;
      r_cand_pol <= w_cand_nx;
      r_pol_inv  <= w_pol_nx;
      r_rxslide  <= w_slide_nx;
      r_fail     <= w_fail_nx;
      r_avalid   <= i_rx_valid && (w_state_nx == ST_LOCKED);
      if (i_rx_valid) r_data <= i_rx_data ^ {W{w_dp_pol}};
    end
  end

  assign o_rxslide       = r_rxslide;
  assign o_slip_pos      = r_slip_pos;
  assign o_polarity_inv  = r_pol_inv;
  assign o_align_fail    = r_fail;
  assign o_bit_locked    = (r_state == ST_LOCKED);
  assign o_data_aligned  = r_data;
  assign o_aligned_valid = r_avalid;

`ifdef BIT_ALIGNER_STATS_EN
  logic [15:0] r_slip_total;
  logic [7:0]  r_unlock_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slip_total <= '0;
      r_unlock_cnt <= '0;
    end else begin
      if (w_slide_nx && r_slip_total != 16'hFFFF) r_slip_total <= r_slip_total + 16'd1;
      if (w_unlock && r_unlock_cnt != 8'hFF)      r_unlock_cnt <= r_unlock_cnt + 8'd1;
    end
  end

  assign o_slip_total = r_slip_total;
  assign o_unlock_cnt = r_unlock_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_unlock;
  assign o_slip_total   = '0;
  assign o_unlock_cnt   = '0;
`endif
endmodule
